// File: rtl/flush_pkg.sv
// Shared types and defaults for the pipeline flush controller.
package flush_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int CNT_W            = 8;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF      = 16;

endpackage

// File: rtl/flush_ctrl.sv
// Flush controller: drains in-flight work (bounded by TIMEOUT), then holds
// flush for FLUSH_CYCLES and pulses done. force_flush skips the drain.
module flush_ctrl
    import flush_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic force_flush,
    input  logic pipe_busy,
    output logic flush,
    output logic done,
    output logic timed_out
);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             flush_q, done_q;
    logic             accept;

    assign req_ready = (state_q == ST_IDLE) & ~force_flush;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        unique case (state_q)
            ST_IDLE: begin
                if (force_flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (force_flush || !pipe_busy) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // A force mid-flush restarts the whole window.
                if (force_flush) begin
                    cnt_d = '0;
                end else if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (force_flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // flush/done come straight from flops so downstream sees clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            flush_q <= (state_d == ST_FLUSH);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign flush     = flush_q;
    assign done      = done_q;
    assign timed_out = to_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed-vector bench for flush_ctrl with FLUSH_CYCLES=2, TIMEOUT=4.
module tb_flush_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic force_flush = 1'b0;
    logic pipe_busy = 1'b0;
    logic req_ready, flush, done, timed_out;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cn = 0;
    string scn = "init";

    flush_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .force_flush (force_flush),
        .pipe_busy   (pipe_busy),
        .flush       (flush),
        .done        (done),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check all outputs, advance past the next edge.
    task automatic cyc(input logic rv, input logic ff, input logic busy,
                       input logic efl, input logic edn, input logic erdy, input logic eto);
        req_valid   = rv;
        force_flush = ff;
        pipe_busy   = busy;
        #1;
        chk($sformatf("%s c%0d flush", scn, cn), flush, efl);
        chk($sformatf("%s c%0d done", scn, cn), done, edn);
        chk($sformatf("%s c%0d req_ready", scn, cn), req_ready, erdy);
        chk($sformatf("%s c%0d timed_out", scn, cn), timed_out, eto);
        cn++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        scn = name;
        req_valid   = 1'b0;
        force_flush = 1'b0;
        pipe_busy   = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk({name, " rst flush"}, flush, 1'b0);
        chk({name, " rst done"}, done, 1'b0);
        chk({name, " rst timed_out"}, timed_out, 1'b0);
        chk({name, " rst req_ready"}, req_ready, 1'b1);
        @(posedge clk);
        #1;
        chk({name, " rst hold flush"}, flush, 1'b0);
        rst_n = 1'b1;
        cn = 0;
    endtask

    task automatic seq_basic();
        cyc(1, 0, 0,  0, 0, 1, 0);
        cyc(0, 0, 0,  0, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 1, 0);
    endtask

    initial begin
        // Reset while forcing: req_ready must still follow force_flush.
        force_flush = 1'b1;
        #2;
        chk("rst ready under force", req_ready, 1'b0);

        do_reset("basic");
        seq_basic();

        do_reset("drain_short");
        cyc(1, 0, 0,  0, 0, 1, 0);
        cyc(0, 0, 1,  0, 0, 0, 0);
        cyc(0, 0, 1,  0, 0, 0, 0);
        cyc(0, 0, 0,  0, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 1, 0);

        do_reset("timeout");
        cyc(1, 0, 1,  0, 0, 1, 0);
        cyc(0, 0, 1,  0, 0, 0, 0);
        cyc(0, 0, 1,  0, 0, 0, 0);
        cyc(0, 0, 1,  0, 0, 0, 0);
        cyc(0, 0, 1,  0, 0, 0, 0);
        cyc(0, 0, 1,  1, 0, 0, 1);
        cyc(0, 0, 1,  1, 0, 0, 1);
        cyc(0, 0, 1,  0, 1, 0, 1);
        // Forced flush leaves the sticky flag alone.
        cyc(0, 1, 0,  0, 0, 0, 1);
        cyc(0, 0, 0,  1, 0, 0, 1);
        cyc(0, 0, 0,  1, 0, 0, 1);
        cyc(0, 0, 0,  0, 1, 0, 1);
        // A fresh accept clears it.
        cyc(1, 0, 0,  0, 0, 1, 1);
        cyc(0, 0, 0,  0, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 1, 0);

        do_reset("force");
        cyc(1, 1, 0,  0, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 1, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0);
        cyc(0, 1, 0,  0, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 1, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 1, 0);

        do_reset("force_drain");
        cyc(1, 0, 1,  0, 0, 1, 0);
        cyc(0, 1, 1,  0, 0, 0, 0);
        cyc(0, 0, 1,  1, 0, 0, 0);
        cyc(0, 0, 1,  1, 0, 0, 0);
        cyc(0, 0, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 1, 0);

        do_reset("mid_rst");
        cyc(1, 0, 0,  0, 0, 1, 0);
        cyc(0, 0, 0,  0, 0, 0, 0);
        #1;
        chk("mid_rst flush before", flush, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst flush async", flush, 1'b0);
        chk("mid_rst done async", done, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst no done", done, 1'b0);
        chk("mid_rst flush held", flush, 1'b0);
        rst_n = 1'b1;
        scn = "after_rst";
        cn = 0;
        seq_basic();

        do_reset("held_req");
        cyc(1, 0, 0,  0, 0, 1, 0);
        cyc(1, 0, 0,  0, 0, 0, 0);
        cyc(1, 0, 0,  1, 0, 0, 0);
        cyc(1, 0, 0,  1, 0, 0, 0);
        cyc(1, 0, 0,  0, 1, 0, 0);
        cyc(1, 0, 0,  0, 0, 1, 0);
        cyc(1, 0, 0,  0, 0, 0, 0);
        cyc(1, 0, 0,  1, 0, 0, 0);
        cyc(1, 0, 0,  1, 0, 0, 0);
        cyc(1, 0, 0,  0, 1, 0, 0);
        cyc(0, 0, 0,  0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
